// File: rtl/pong_match_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : pong_match_controller_if
// Description : Match-level signal bundle between the match controller and
//               its environment.
//               Controller inputs:
//                 start, pause        : button levels
//                 miss_left/right     : miss pulses from the physics updater
//               Controller outputs:
//                 state, play_en      : match state and motion enable
//                 serve_req/dir       : ball launch request and direction
//                 player1/2_score     : scores
//                 game_over, winner   : end-of-match status
//               The "slave" modport is the controller side. The "master"
//               modport is the environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pong_match_controller_if;
    logic       start;
    logic       pause;
    logic       miss_left;
    logic       miss_right;
    logic [2:0] state;
    logic       play_en;
    logic       serve_req;
    logic       serve_dir;
    logic [7:0] player1_score;
    logic [7:0] player2_score;
    logic       game_over;
    logic       winner;

    modport slave (
        input  start, pause, miss_left, miss_right,
        output state, play_en, serve_req, serve_dir,
               player1_score, player2_score, game_over, winner
    );

    modport master (
        output start, pause, miss_left, miss_right,
        input  state, play_en, serve_req, serve_dir,
               player1_score, player2_score, game_over, winner
    );
endinterface
`default_nettype wire

// File: rtl/pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : pong_match_controller
// Description : Frame-rate match sequencer for a two-player paddle game.
//               It advances once per vsync rising edge through these states:
//               IDLE, SERVE countdown, PLAY, POINT hold, PAUSED and OVER.
//               It also keeps both scores.
// Ports       : vsync - frame clock, one rising edge per frame
//               rst   - synchronous active-high reset
//               bus   - pong_match_controller_if.slave. It carries the button
//                       and miss inputs, and the registered state, score,
//                       serve and game-over outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_match_controller #(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned POINT_HOLD  = 90
) (
    input  wire                         vsync,
    input  wire                         rst,
    pong_match_controller_if.slave      bus
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SERVE  = 3'd1;
    localparam logic [2:0] c_ST_PLAY   = 3'd2;
    localparam logic [2:0] c_ST_POINT  = 3'd3;
    localparam logic [2:0] c_ST_OVER   = 3'd4;
    localparam logic [2:0] c_ST_PAUSED = 3'd5;

    // The frame counter is at least 8 bits wide.
    // It grows only if a delay parameter does not fit in 8 bits.
    localparam int unsigned c_MAX_LOAD = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
    localparam int unsigned c_CNT_W    = ($clog2(c_MAX_LOAD) > 8) ? $clog2(c_MAX_LOAD) : 8;
    localparam logic [c_CNT_W-1:0] c_SERVE_LOAD = c_CNT_W'(SERVE_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD  = c_CNT_W'(POINT_HOLD - 1);
    localparam logic [7:0]         c_WIN        = 8'(WIN_SCORE);

    logic [2:0]         r_state, w_state_nxt;
    logic [2:0]         r_saved, w_saved_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]         r_p1, w_p1_nxt;
    logic [7:0]         r_p2, w_p2_nxt;
    logic               r_dir, w_dir_nxt;
    logic               r_winner, w_winner_nxt;
    logic               r_play_en, w_play_en_nxt;
    logic               r_serve_req, w_serve_req_nxt;
    logic               r_game_over, w_game_over_nxt;
    logic               r_start_q, r_pause_q;

    wire w_start_edge = bus.start & ~r_start_q;
    wire w_pause_edge = bus.pause & ~r_pause_q;
    wire w_cnt_zero   = (r_cnt == '0);

    // State and output registers.
    // The edge-detect history resets high, so a button that is held through
    // reset does not fire when reset is released.
    always_ff @(posedge vsync) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_saved     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_dir       <= 1'b1;
            r_winner    <= 1'b0;
            r_play_en   <= 1'b0;
            r_serve_req <= 1'b0;
            r_game_over <= 1'b0;
            r_start_q   <= 1'b1;
            r_pause_q   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_saved     <= w_saved_nxt;
            r_cnt       <= w_cnt_nxt;
            r_p1        <= w_p1_nxt;
            r_p2        <= w_p2_nxt;
            r_dir       <= w_dir_nxt;
            r_winner    <= w_winner_nxt;
            r_play_en   <= w_play_en_nxt;
            r_serve_req <= w_serve_req_nxt;
            r_game_over <= w_game_over_nxt;
            r_start_q   <= bus.start;
            r_pause_q   <= bus.pause;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_saved_nxt  = r_saved;
        w_cnt_nxt    = r_cnt;
        w_p1_nxt     = r_p1;
        w_p2_nxt     = r_p2;
        w_dir_nxt    = r_dir;
        w_winner_nxt = r_winner;
        case (r_state)
            c_ST_IDLE: begin
                w_p1_nxt = '0;
                w_p2_nxt = '0;
                if (w_start_edge) begin
                    w_state_nxt = c_ST_SERVE;
                    w_cnt_nxt   = c_SERVE_LOAD;
                    w_dir_nxt   = 1'b1;
                end
            end
            c_ST_SERVE: begin
                // A pause edge takes precedence over an expiring countdown.
                // The launch then happens on the first frame after resume.
                if (w_pause_edge) begin
                    w_saved_nxt = c_ST_SERVE;
                    w_state_nxt = c_ST_PAUSED;
                end else if (w_cnt_zero) begin
                    w_state_nxt = c_ST_PLAY;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            c_ST_PLAY: begin
                // A miss beats a pause edge in the same frame.
                // A simultaneous double miss is a replay: no score change.
                if (bus.miss_left || bus.miss_right) begin
                    w_state_nxt = c_ST_POINT;
                    w_cnt_nxt   = c_HOLD_LOAD;
                    if (bus.miss_left && !bus.miss_right) begin
                        w_p2_nxt  = r_p2 + 8'd1;
                        w_dir_nxt = 1'b0;
                    end else if (bus.miss_right && !bus.miss_left) begin
                        w_p1_nxt  = r_p1 + 8'd1;
                        w_dir_nxt = 1'b1;
                    end
                end else if (w_pause_edge) begin
                    w_saved_nxt = c_ST_PLAY;
                    w_state_nxt = c_ST_PAUSED;
                end
            end
            c_ST_POINT: begin
                if (w_cnt_zero) begin
                    if (r_p1 >= c_WIN || r_p2 >= c_WIN) begin
                        w_state_nxt  = c_ST_OVER;
                        w_winner_nxt = (r_p2 >= c_WIN);
                    end else begin
                        w_state_nxt = c_ST_SERVE;
                        w_cnt_nxt   = c_SERVE_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            c_ST_OVER: begin
                if (w_start_edge) begin
                    w_p1_nxt    = '0;
                    w_p2_nxt    = '0;
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = c_ST_SERVE;
                    w_cnt_nxt   = c_SERVE_LOAD;
                end
            end
            c_ST_PAUSED: begin
                // Resume without touching the counter.
                if (w_pause_edge) begin
                    w_state_nxt = r_saved;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_p1_nxt    = '0;
                w_p2_nxt    = '0;
            end
        endcase
    end

    // Registered outputs are decoded from the upcoming state.
    // A serve request is raised only on the SERVE to PLAY launch, never on a
    // resume from PAUSED.
    always_comb begin
        w_play_en_nxt   = (w_state_nxt == c_ST_PLAY);
        w_serve_req_nxt = (r_state == c_ST_SERVE) && (w_state_nxt == c_ST_PLAY);
        w_game_over_nxt = (w_state_nxt == c_ST_OVER);
    end

    assign bus.state         = r_state;
    assign bus.play_en       = r_play_en;
    assign bus.serve_req     = r_serve_req;
    assign bus.serve_dir     = r_dir;
    assign bus.player1_score = r_p1;
    assign bus.player2_score = r_p2;
    assign bus.game_over     = r_game_over;
    assign bus.winner        = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_match_controller
// Description : Scoreboard bench for pong_match_controller
//               (WIN_SCORE=2, SERVE_DELAY=3, POINT_HOLD=2).
//               A frame-level reference model predicts every frame's outputs.
//               A monitor compares them with the DUT after each vsync edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_match_controller;

    localparam int unsigned WIN   = 2;
    localparam int unsigned SDLY  = 3;
    localparam int unsigned PHOLD = 2;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4, S_PAUSED = 5;

    typedef struct packed {
        logic [2:0] state;
        logic       play_en;
        logic       serve_req;
        logic       serve_dir;
        logic [7:0] p1;
        logic [7:0] p2;
        logic       game_over;
        logic       winner;
    } obs_t;

    logic vsync = 1'b0;
    logic rst   = 1'b1;

    pong_match_controller_if bus();

    pong_match_controller #(
        .WIN_SCORE  (WIN),
        .SERVE_DELAY(SDLY),
        .POINT_HOLD (PHOLD)
    ) dut (
        .vsync(vsync),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 vsync = ~vsync;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    frame_no = 0;
    string phase = "init";
    bit    lvl_start = 1'b0;
    bit    lvl_pause = 1'b0;

    // Reference model, kept at the match level.
    // Each countdown counts the frames left until its event; pause freezes it.
    int m_mode, m_resume, m_wait, m_hold;
    int m_p1, m_p2;
    bit m_dir, m_winner, m_launch, m_prev_start, m_prev_pause;

    task automatic begin_serve();
        m_mode = S_SERVE;
        m_wait = SDLY;
    endtask

    task automatic model_step(input bit r, input bit st, input bit pa, input bit ml, input bit mr);
        bit se, pe;
        m_launch = 1'b0;
        if (r) begin
            m_mode = S_IDLE; m_resume = S_IDLE; m_wait = 0; m_hold = 0;
            m_p1 = 0; m_p2 = 0; m_dir = 1'b1; m_winner = 1'b0;
            m_prev_start = 1'b1; m_prev_pause = 1'b1;
            return;
        end
        se = st && !m_prev_start;
        pe = pa && !m_prev_pause;
        m_prev_start = st;
        m_prev_pause = pa;
        case (m_mode)
            S_IDLE: if (se) begin m_dir = 1'b1; begin_serve(); end
            S_SERVE: begin
                if (pe) begin
                    m_resume = S_SERVE;
                    m_mode   = S_PAUSED;
                end else begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_launch = 1'b1;
                        m_mode   = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (ml || mr) begin
                    m_mode = S_POINT;
                    m_hold = PHOLD;
                    if (ml && !mr) begin m_p2++; m_dir = 1'b0; end
                    if (mr && !ml) begin m_p1++; m_dir = 1'b1; end
                end else if (pe) begin
                    m_resume = S_PLAY;
                    m_mode   = S_PAUSED;
                end
            end
            S_POINT: begin
                m_hold--;
                if (m_hold == 0) begin
                    if (m_p1 >= WIN || m_p2 >= WIN) begin
                        m_mode   = S_OVER;
                        m_winner = (m_p2 >= WIN);
                    end else begin
                        begin_serve();
                    end
                end
            end
            S_OVER: if (se) begin m_p1 = 0; m_p2 = 0; m_dir = 1'b1; begin_serve(); end
            S_PAUSED: if (pe) m_mode = m_resume;
            default: m_mode = S_IDLE;
        endcase
    endtask

    // One frame of stimulus.
    // The inputs are driven mid-frame, and the predicted outputs for the
    // coming edge are queued.
    task automatic step(input bit r, input bit st, input bit pa, input bit ml, input bit mr);
        obs_t e;
        @(negedge vsync);
        rst            = r;
        bus.start      = st;
        bus.pause      = pa;
        bus.miss_left  = ml;
        bus.miss_right = mr;
        lvl_start = st;
        lvl_pause = pa;
        model_step(r, st, pa, ml, mr);
        e.state     = 3'(m_mode);
        e.play_en   = (m_mode == S_PLAY);
        e.serve_req = m_launch;
        e.serve_dir = m_dir;
        e.p1        = 8'(m_p1);
        e.p2        = 8'(m_p2);
        e.game_over = (m_mode == S_OVER);
        e.winner    = m_winner;
        exp_q.push_back(e);
        tag_q.push_back(phase);
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) step(1'b0, lvl_start, lvl_pause, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int target, input int limit);
        int k;
        k = 0;
        while (m_mode != target && k < limit) begin
            step(1'b0, lvl_start, lvl_pause, 1'b0, 1'b0);
            k++;
        end
        if (m_mode != target) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_until[%s]: reached mode %0d, required %0d within %0d frames",
                     phase, m_mode, target, limit);
        end
    endtask

    // Monitor: the DUT presents a fresh output set on every frame edge.
    always @(posedge vsync) begin
        obs_t  a, e;
        string t;
        #1;
        frame_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a.state     = bus.state;
            a.play_en   = bus.play_en;
            a.serve_req = bus.serve_req;
            a.serve_dir = bus.serve_dir;
            a.p1        = bus.player1_score;
            a.p2        = bus.player2_score;
            a.game_over = bus.game_over;
            a.winner    = bus.winner;
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL frame %0d [%s]: got st=%0d en=%0b req=%0b dir=%0b p1=%0d p2=%0d go=%0b win=%0b, expected st=%0d en=%0b req=%0b dir=%0b p1=%0d p2=%0d go=%0b win=%0b",
                         frame_no, t, a.state, a.play_en, a.serve_req, a.serve_dir, a.p1, a.p2,
                         a.game_over, a.winner, e.state, e.play_en, e.serve_req, e.serve_dir,
                         e.p1, e.p2, e.game_over, e.winner);
            end
        end
    end

    initial begin
        bus.start = 1'b1; bus.pause = 1'b0; bus.miss_left = 1'b0; bus.miss_right = 1'b0;

        phase = "reset_start_held";
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        phase = "start_edge_launch";
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle_frames(SDLY);

        phase = "miss_left";
        step(0, 1, 0, 1, 0);
        idle_frames(PHOLD + SDLY + 1);

        phase = "double_miss";
        step(0, 1, 0, 1, 1);
        run_until(S_SERVE, 10);

        phase = "pause_in_serve";
        idle_frames(1);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, i[0], ~i[0]);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        idle_frames(3);

        phase = "win_p1";
        run_until(S_PLAY, 10);
        step(0, 1, 1, 0, 1);
        run_until(S_PLAY, 10);
        step(0, 1, 1, 0, 1);
        run_until(S_OVER, 10);
        idle_frames(2);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        phase = "pause_in_play";
        run_until(S_PLAY, 10);
        step(0, 1, 1, 0, 0);
        idle_frames(3);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        idle_frames(2);

        phase = "reset_mid_play";
        step(0, 1, 0, 0, 1);
        run_until(S_PLAY, 10);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0);
        end

        phase = "drain";
        @(negedge vsync);
        @(negedge vsync);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected frames left unchecked, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pong_match_controller.md
# pong_match_controller

Frame-rate match sequencer for the two-player paddle game. It owns the match-level state: idle, serve countdown, live play, point hold, pause and game over. It also owns the two scores. It tells the ball/paddle physics updater when to move (`play_en`), when to launch the ball (`serve_req`/`serve_dir`) and when to freeze. It consumes miss events reported back by that updater and feeds the scores and game-over status to the renderer. It ticks once per frame on `vsync`.

## Interface
- `WIN_SCORE`, 7: points needed to win; 1..255.
- `SERVE_DELAY`, 60: frames spent in SERVE before launch; ≥1.
- `POINT_HOLD`, 90: frames spent frozen after a point; ≥1.

- `vsync` in 1: clock, one rising edge per frame.
- `rst` in 1: reset; synchronous, active-high; sampled on `vsync` rising edge.
- `start` in 1: any-button level; only its rising edge acts.
- `pause` in 1: pause button level; only its rising edge acts.
- `miss_left` in 1: ball passed player 1's paddle (player 2 scores); one-frame pulse.
- `miss_right` in 1: ball passed player 2's paddle (player 1 scores); one-frame pulse.
- `state` out 3: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSED=5.
- `play_en` out 1: updater may integrate ball/paddle motion this frame.
- `serve_req` out 1: one-frame pulse; updater recenters ball and launches it.
- `serve_dir` out 1: launch direction; 0=left (toward P1), 1=right (toward P2).
- `player1_score` out 8: player 1 score.
- `player2_score` out 8: player 2 score.
- `game_over` out 1: high only in OVER.
- `winner` out 1: 0=P1, 1=P2; valid while `game_over` is high.

## Operation
- All outputs are registered and update on the `vsync` rising edge.
- Edge detect: `start_q` and `pause_q` register the previous level. An edge is `x & ~x_q`. Reset loads both `_q` registers to 1, so a button held through reset does not fire.
- Frame counter: 8 bits wide, or wider if a parameter needs it. It loads N−1 on entering SERVE/POINT and decrements once per frame. Expiry is the frame in which it reads 0.
- IDLE: scores 0, `play_en` 0. A start edge moves to SERVE: counter = SERVE_DELAY−1, `serve_dir` = 1.
- SERVE: `play_en` 0. Misses are ignored. On expiry, `serve_req` = 1 and `play_en` = 1 in the same frame, and the state moves to PLAY.
- PLAY: `play_en` 1.
  - `miss_left` only: P2 score +1, `serve_dir` = 0.
  - `miss_right` only: P1 score +1, `serve_dir` = 1.
  - In both cases the state moves to POINT with counter = POINT_HOLD−1 and `play_en` 0 from that frame.
  - Both misses in the same frame: no score change, `serve_dir` unchanged, move to POINT (replay).
- POINT: `play_en` 0. Misses are ignored. On expiry:
  - If either score ≥ WIN_SCORE, go to OVER with `winner` = 1 if P2 reached it, else 0.
  - Otherwise go to SERVE with counter = SERVE_DELAY−1.
- Pause: a pause edge in SERVE or PLAY stores the current state and goes to PAUSED. In PAUSED, `play_en` is 0, the counter is held and misses are ignored. A pause edge in PAUSED restores the stored state and the held counter. If the restored state is PLAY, `play_en` is 1. Pause edges are ignored in IDLE, POINT and OVER.
- Priority when pause and a miss arrive in the same PLAY frame: the miss wins and pause is dropped.
- OVER: `game_over` 1, `play_en` 0, scores held. A start edge clears both scores, sets `serve_dir` = 1 and goes to SERVE.
- Start edges outside IDLE and OVER are ignored.
- Scores never exceed WIN_SCORE, because the game ends on reaching it.
- Illegal state encodings return to IDLE next frame, with scores cleared.

## Timing
- Reset values: `state` IDLE, `play_en` 0, `serve_req` 0, `serve_dir` 1, both scores 0, `game_over` 0, `winner` 0. Reset overrides every other input, including mid-play and mid-pause.
- Start edge sampled at frame N: `state` = SERVE at N. Launch (`serve_req` = 1, `state` = PLAY) at N+SERVE_DELAY.
- Miss sampled at frame M: score and `state` = POINT at M, `play_en` 0 at M. The next exit from POINT is at M+POINT_HOLD.
- `serve_req` is high for exactly one frame per serve and never occurs outside the SERVE→PLAY transition.

## Test plan
- Test parameters: WIN_SCORE=2, SERVE_DELAY=3, POINT_HOLD=2.
- Reset with `start` held high, then release reset → stays IDLE. Drop and re-raise `start` → SERVE. Exactly 3 frames later: `serve_req` = 1 for one frame, `play_en` = 1, `state` = 2.
- In PLAY, pulse `miss_left` → `player2_score` = 1, `serve_dir` = 0, `state` = 3, `play_en` = 0. 2 frames later `state` = 1. 3 frames after that, `serve_req` pulses.
- In PLAY, pulse `miss_left` and `miss_right` together → scores unchanged, `state` = POINT, `serve_dir` unchanged.
- Pause edge in SERVE with the counter at 1 → `state` = 5. Hold for 10 frames: `play_en` 0 throughout, misses ignored. Pause edge again → SERVE resumes with the counter at 1, and launch follows 2 frames later.
- Score two `miss_right` points → after the hold, `state` = 4, `game_over` = 1, `winner` = 0, `player1_score` = 2. Start edge → both scores 0, `state` = 1.
- Assert `rst` for one frame during PLAY with `player1_score` = 1 → all outputs return to their reset values on the next frame.
